// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two DataMemory requesters, the arbiter and DataMemory.
//   Requester 0 (CPU) : req0, we0, lock0, addr0, wdata0 -> gnt0, rdata0
//   Requester 1 (DMA) : req1, we1, lock1, addr1, wdata1 -> gnt1, rdata1
//   DataMemory side   : memAddress, memWriteData, memRead, memWrite <- memReadData
//   Status            : busy, owner (burst ownership)
// slave modport = arbiter view, master modport = requesters/memory view.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req0, req1;
    logic                  we0, we1;
    logic                  lock0, lock1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic                  memRead, memWrite;
    logic [DATA_WIDTH-1:0] memReadData;
    logic                  busy, owner;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        input  memReadData,
        output gnt0, gnt1, rdata0, rdata1,
        output memAddress, memWriteData, memRead, memWrite,
        output busy, owner
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        output memReadData,
        input  gnt0, gnt1, rdata0, rdata1,
        input  memAddress, memWriteData, memRead, memWrite,
        input  busy, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported DataMemory between requester 0 (CPU load/store)
// and requester 1 (DMA/debug loader). At most one zero-latency access per
// cycle: round-robin between simultaneous requests, with an optional locked
// burst of up to MAX_BURST beats for one requester.
// Ports:
//   clk    - system clock, rising edge
//   resetN - asynchronous active-low reset
//   bus    - dmem_arbiter_if.slave (requests/grants, DataMemory drive, busy/owner)
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input logic           clk,
    input logic           resetN,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state, stateNext;
    logic             lastGrant, lastGrantNext;
    logic [CNT_W-1:0] beatCnt, beatCntNext, beatInc;
    logic             busyR, ownerR;

    logic gntAny, gntIdx;
    logic gLock, gWe;

    // Grant selection; reset gates every grant so no strobe reaches memory.
    always_comb begin
        gntAny = 1'b0;
        gntIdx = 1'b0;
        if (resetN) begin
            case (state)
                IDLE: begin
                    if (bus.req0 && bus.req1) begin
                        gntAny = 1'b1;
                        gntIdx = ~lastGrant;
                    end else if (bus.req0) begin
                        gntAny = 1'b1;
                    end else if (bus.req1) begin
                        gntAny = 1'b1;
                        gntIdx = 1'b1;
                    end
                end
                OWN0: gntAny = bus.req0;
                OWN1: begin
                    gntAny = bus.req1;
                    gntIdx = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gLock = gntIdx ? bus.lock1 : bus.lock0;
    assign gWe   = gntIdx ? bus.we1   : bus.we0;

    assign bus.gnt0         = gntAny & ~gntIdx;
    assign bus.gnt1         = gntAny &  gntIdx;
    assign bus.memAddress   = gntAny ? (gntIdx ? bus.addr1 : bus.addr0) : '0;
    assign bus.memWriteData = gntAny ? (gntIdx ? bus.wdata1 : bus.wdata0) : '0;
    assign bus.memRead      = gntAny & ~gWe;
    assign bus.memWrite     = gntAny &  gWe;
    assign bus.rdata0       = (bus.gnt0 && !bus.we0) ? bus.memReadData : '0;
    assign bus.rdata1       = (bus.gnt1 && !bus.we1) ? bus.memReadData : '0;
    assign bus.busy         = busyR;
    assign bus.owner        = ownerR;

    assign beatInc = beatCnt + CNT_W'(1);

    always_comb begin
        stateNext     = state;
        beatCntNext   = beatCnt;
        lastGrantNext = lastGrant;
        if (gntAny) begin
            lastGrantNext = gntIdx;
            if (state == IDLE) begin
                // A single-beat burst limit means a lock never takes ownership.
                if (gLock && (MAX_BURST > 1)) begin
                    stateNext   = gntIdx ? OWN1 : OWN0;
                    beatCntNext = CNT_W'(1);
                end else begin
                    beatCntNext = '0;
                end
            end else if (!gLock || (beatInc == CNT_W'(MAX_BURST))) begin
                stateNext   = IDLE;
                beatCntNext = '0;
            end else begin
                beatCntNext = beatInc;
            end
        end else if (state != IDLE) begin
            // Owner dropped its request: release without granting this cycle.
            stateNext   = IDLE;
            beatCntNext = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            beatCnt   <= '0;
            busyR     <= 1'b0;
            ownerR    <= 1'b0;
        end else begin
            state     <= stateNext;
            lastGrant <= lastGrantNext;
            beatCnt   <= beatCntNext;
            busyR     <= (stateNext != IDLE);
            if (stateNext != IDLE) begin
                ownerR <= (stateNext == OWN1);
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural DataMemory
// (combinational read, write on the rising edge).
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic resetN = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(8)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    logic [31:0] mem [0:63];
    assign bus.memReadData = mem[bus.memAddress[5:0]];
    always @(posedge clk) begin
        if (bus.memWrite) mem[bus.memAddress[5:0]] <= bus.memWriteData;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        r0, r1, w0, w1, l0, l1;
        logic [31:0] a0, a1, d0, d1;
        logic        g0, g1, rd, wr;
        logic [31:0] ma, q0, q1;
        logic        b, o;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r0, r1, w0, w1, l0, l1,
                                input logic [31:0] a0, a1, d0, d1,
                                input logic g0, g1, rd, wr,
                                input logic [31:0] ma, q0, q1,
                                input logic b, o);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rd = rd; v.wr = wr;
        v.ma = ma; v.q0 = q0; v.q1 = q1; v.b = b; v.o = o;
        return v;
    endfunction

    task automatic drive(input logic r0, r1, w0, w1, l0, l1,
                         input logic [31:0] a0, a1, d0, d1);
        bus.req0 = r0; bus.req1 = r1; bus.we0 = w0; bus.we1 = w1;
        bus.lock0 = l0; bus.lock1 = l1;
        bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] DEAD = 32'hdead0000;
    localparam logic [31:0] BEEF = 32'h0000beef;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Write 10, read back, then interleaved write 18 / read 10, read 18.
        vecs.push_back(mk(1,0,1,0,0,0, 10,0,DEAD,0,  1,0,0,1, 10,0,0,    0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 10,0,0,0,     1,0,1,0, 10,DEAD,0, 0,0));
        vecs.push_back(mk(1,1,0,1,0,0, 10,18,0,BEEF, 0,1,0,1, 18,0,0,    0,0));
        vecs.push_back(mk(1,1,0,1,0,0, 10,18,0,BEEF, 1,0,1,0, 10,DEAD,0, 0,0));
        vecs.push_back(mk(1,1,0,1,0,0, 10,18,0,BEEF, 0,1,0,1, 18,0,0,    0,0));
        vecs.push_back(mk(1,1,0,1,0,0, 10,18,0,BEEF, 1,0,1,0, 10,DEAD,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,18,0,0,     0,1,1,0, 18,0,BEEF, 0,0));
        // Full 8-beat burst by requester 0 while requester 1 waits.
        vecs.push_back(mk(1,1,0,0,1,0, 10,18,0,0,    1,0,1,0, 10,DEAD,0, 0,0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1,1,0,0,1,0, 10,18,0,0, 1,0,1,0, 10,DEAD,0, 1,0));
        vecs.push_back(mk(1,1,0,0,1,0, 10,18,0,0,    0,1,1,0, 18,0,BEEF, 0,0));
        // Requester 1 bursts 3 beats then drops; requester 0 lock is ignored.
        vecs.push_back(mk(0,1,0,0,0,1, 10,18,0,0,    0,1,1,0, 18,0,BEEF, 0,0));
        vecs.push_back(mk(1,1,0,0,1,1, 10,18,0,0,    0,1,1,0, 18,0,BEEF, 1,1));
        vecs.push_back(mk(1,1,0,0,1,1, 10,18,0,0,    0,1,1,0, 18,0,BEEF, 1,1));
        vecs.push_back(mk(1,0,0,0,1,0, 10,18,0,0,    0,0,0,0, 0,0,0,     1,1));
        vecs.push_back(mk(1,0,0,0,0,0, 10,18,0,0,    1,0,1,0, 10,DEAD,0, 0,1));

        // Reset state, with both requests asserted.
        drive(1,1,1,1,0,0, 10,18,32'h1,32'h2);
        #2;
        chk("rst_gnt0", {31'b0, bus.gnt0}, 0);
        chk("rst_gnt1", {31'b0, bus.gnt1}, 0);
        chk("rst_memWrite", {31'b0, bus.memWrite}, 0);
        chk("rst_memRead", {31'b0, bus.memRead}, 0);
        chk("rst_memAddress", bus.memAddress, 0);
        chk("rst_memWriteData", bus.memWriteData, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_owner", {31'b0, bus.owner}, 0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;

        foreach (vecs[i]) begin
            vec_t v;
            string n;
            v = vecs[i];
            drive(v.r0, v.r1, v.w0, v.w1, v.l0, v.l1, v.a0, v.a1, v.d0, v.d1);
            #1;
            n = $sformatf("v%0d_", i);
            chk({n, "gnt0"}, {31'b0, bus.gnt0}, {31'b0, v.g0});
            chk({n, "gnt1"}, {31'b0, bus.gnt1}, {31'b0, v.g1});
            chk({n, "memRead"}, {31'b0, bus.memRead}, {31'b0, v.rd});
            chk({n, "memWrite"}, {31'b0, bus.memWrite}, {31'b0, v.wr});
            chk({n, "memAddress"}, bus.memAddress, v.ma);
            chk({n, "rdata0"}, bus.rdata0, v.q0);
            chk({n, "rdata1"}, bus.rdata1, v.q1);
            chk({n, "busy"}, {31'b0, bus.busy}, {31'b0, v.b});
            chk({n, "owner"}, {31'b0, bus.owner}, {31'b0, v.o});
            @(negedge clk);
        end

        // Reset mid-burst after three locked beats by requester 0.
        drive(1,0,0,0,1,0, 10,0,0,0);
        repeat (3) @(negedge clk);
        drive(1,0,1,0,1,0, 30,0,32'h1234,0);
        #1;
        chk("pre_rst_busy", {31'b0, bus.busy}, 1);
        chk("pre_rst_gnt0", {31'b0, bus.gnt0}, 1);
        resetN = 1'b0;
        #1;
        chk("mid_rst_gnt0", {31'b0, bus.gnt0}, 0);
        chk("mid_rst_gnt1", {31'b0, bus.gnt1}, 0);
        chk("mid_rst_memWrite", {31'b0, bus.memWrite}, 0);
        chk("mid_rst_memAddress", bus.memAddress, 0);
        chk("mid_rst_busy", {31'b0, bus.busy}, 0);
        chk("mid_rst_owner", {31'b0, bus.owner}, 0);
        @(negedge clk);
        chk("rst_no_commit", mem[30], 0);
        resetN = 1'b1;
        drive(1,1,0,0,0,0, 10,18,0,0);
        #1;
        chk("post_rst_tie_gnt0", {31'b0, bus.gnt0}, 1);
        chk("post_rst_tie_gnt1", {31'b0, bus.gnt1}, 0);
        @(negedge clk);
        #1;
        chk("post_rst_tie2_gnt1", {31'b0, bus.gnt1}, 1);
        chk("post_rst_tie2_rdata1", bus.rdata1, BEEF);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
